// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, arbiter states and writeback request type
package wb_port_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef enum logic {NORMAL = 1'b0, DRAIN = 1'b1} arb_state_e;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: circular buffer of pending LLU results with count, full and empty
module wb_result_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 37
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  // a full buffer may still take a push when the head leaves in the same cycle
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage needs no reset; resetting the pointers discards its contents
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline writeback and buffered LLU results
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int MAX_WAIT = 8,
  parameter int XLEN = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   pipe_valid,
  input  logic [wb_port_arbiter_pkg::REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]                        pipe_data,
  output logic                                   stall_pipe,
  input  logic                                   llu_valid,
  output logic                                   llu_ready,
  input  logic [wb_port_arbiter_pkg::REG_ADDR_W-1:0] llu_rd,
  input  logic [XLEN-1:0]                        llu_data,
  output logic                                   rf_we,
  output logic [wb_port_arbiter_pkg::REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]                        rf_wdata,
  output logic                                   llu_pending
);
  import wb_port_arbiter_pkg::*;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int AGW = $clog2(MAX_WAIT + 1);
  localparam int W   = REG_ADDR_W + XLEN;
  arb_state_e            state_q, state_d;
  logic [AGW-1:0]        age_q, age_d;
  logic [CW-1:0]         count, count_d;
  logic [W-1:0]          head;
  logic                  full, empty, push, pop, force_drain, grant_pipe;
  logic                  rf_we_q, llu_ready_q, llu_pending_q;
  logic [REG_ADDR_W-1:0] rf_waddr_q;
  logic [XLEN-1:0]       rf_wdata_q;
  assign llu_ready   = llu_ready_q;
  assign llu_pending = llu_pending_q;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  wb_result_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({llu_rd, llu_data}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  // arbitration: a forced drain stalls the pipeline, otherwise the pipeline wins and the buffer fills idle slots
  always_comb begin
    push        = llu_valid && llu_ready_q && (llu_rd != '0);
    force_drain = !empty && ((age_q == AGW'(MAX_WAIT)) || (full && llu_valid));
    stall_pipe  = (state_q == NORMAL) && force_drain;
    grant_pipe  = !stall_pipe && pipe_valid;
    pop         = stall_pipe || (!pipe_valid && !empty);
    state_d     = stall_pipe ? DRAIN : NORMAL;
    age_d       = (pop || empty) ? '0 : (age_q == AGW'(MAX_WAIT)) ? age_q : age_q + 1'b1;
    count_d     = count + CW'(push) - CW'(pop);
  end
  // arbiter state and head age
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NORMAL;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
    end
  end
  // write port registers from the granted source, plus buffer status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      llu_ready_q   <= 1'b1;
      llu_pending_q <= 1'b0;
    end else begin
      rf_we_q <= grant_pipe ? (pipe_rd != '0) : pop;
      if (grant_pipe || pop) begin
        rf_waddr_q <= grant_pipe ? pipe_rd : head[W-1 -: REG_ADDR_W];
        rf_wdata_q <= grant_pipe ? pipe_data : head[XLEN-1:0];
      end
      llu_ready_q   <= count_d != CW'(DEPTH);
      llu_pending_q <= count_d != '0;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: random and directed stimulus checked against a queue-based model
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;
  localparam int DEPTH = 2;
  localparam int MAX_WAIT = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pipe_valid = 1'b0, llu_valid = 1'b0;
  logic [4:0] pipe_rd = '0, llu_rd = '0;
  logic [31:0] pipe_data = '0, llu_data = '0;
  logic stall_pipe, llu_ready, rf_we, llu_pending;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  int tests = 0, fails = 0;
  wb_req_t q[$];
  int age;
  bit in_drain, m_we, seen_stall;
  logic [4:0] m_addr;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .stall_pipe(stall_pipe),
    .llu_valid(llu_valid), .llu_ready(llu_ready), .llu_rd(llu_rd), .llu_data(llu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .llu_pending(llu_pending)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    age = 0;
    in_drain = 0;
    m_we = 0;
    m_addr = '0;
    m_data = '0;
  endtask

  // one clock of the model: compare outputs after inputs settle, then advance on the edge
  task automatic tick();
    bit f, gh, gp, push, was_empty;
    wb_req_t h;
    #1;
    was_empty = q.size() == 0;
    f = !in_drain && !was_empty && (age == MAX_WAIT || (q.size() == DEPTH && llu_valid));
    seen_stall = stall_pipe;
    chk("stall_pipe", stall_pipe, f);
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_addr);
    chk("rf_wdata", rf_wdata, m_data);
    chk("llu_ready", llu_ready, q.size() != DEPTH);
    chk("llu_pending", llu_pending, q.size() != 0);
    gp = !f && pipe_valid;
    gh = f || (!pipe_valid && !was_empty);
    push = llu_valid && (q.size() != DEPTH) && (llu_rd != 0);
    @(posedge clk);
    if (gp) begin
      m_we = pipe_rd != 0;
      m_addr = pipe_rd;
      m_data = pipe_data;
    end else if (gh) begin
      h = q.pop_front();
      m_we = 1;
      m_addr = h.rd;
      m_data = h.data;
    end else m_we = 0;
    age = (gh || was_empty) ? 0 : (age < MAX_WAIT ? age + 1 : age);
    if (push) q.push_back('{rd: llu_rd, data: llu_data});
    in_drain = f;
    @(negedge clk);
  endtask

  task automatic async_reset_mid_cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_rf_we", rf_we, 0);
    chk("arst_rf_waddr", rf_waddr, 0);
    chk("arst_rf_wdata", rf_wdata, 0);
    chk("arst_llu_ready", llu_ready, 1);
    chk("arst_llu_pending", llu_pending, 0);
    chk("arst_stall", stall_pipe, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [4:0] llu_seen[$];
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_rf_we", rf_we, 0);
    chk("reset_llu_ready", llu_ready, 1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_stall", seen_stall, 0);
      chk("idle_rf_we", rf_we, 0);
      chk("idle_llu_ready", llu_ready, 1);
      chk("idle_llu_pending", llu_pending, 0);
    end
    pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hDEADBEEF;
    tick();
    pipe_valid = 0;
    chk("pipe_we", rf_we, 1);
    chk("pipe_waddr", rf_waddr, 5);
    chk("pipe_wdata", rf_wdata, 32'hDEADBEEF);
    pipe_valid = 1; pipe_rd = 0; pipe_data = 32'h12345678;
    tick();
    pipe_valid = 0;
    chk("pipe_rd0_we", rf_we, 0);
    tick();
    pipe_valid = 1; pipe_rd = 1; pipe_data = 32'hAAAA0001;
    llu_valid = 1; llu_rd = 7; llu_data = 32'h11;
    tick();
    llu_valid = 0;
    for (n = 1; n <= 20; n++) begin
      tick();
      if (seen_stall) break;
    end
    chk("age_stall_cycle", n, 9);
    chk("age_drain_we", rf_we, 1);
    chk("age_drain_waddr", rf_waddr, 7);
    chk("age_drain_wdata", rf_wdata, 32'h11);
    tick();
    chk("after_drain_stall", seen_stall, 0);
    llu_valid = 1; llu_rd = 3; llu_data = 32'h33;
    tick();
    llu_rd = 4; llu_data = 32'h44;
    tick();
    chk("full_llu_ready", llu_ready, 0);
    llu_rd = 9; llu_data = 32'h99;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rf_we && rf_waddr != 1) llu_seen.push_back(rf_waddr);
    end
    chk("fifo_order_count", llu_seen.size() >= 2, 1);
    if (llu_seen.size() >= 2) begin
      chk("fifo_order_first", llu_seen[0], 3);
      chk("fifo_order_second", llu_seen[1], 4);
    end
    llu_valid = 0; pipe_valid = 0;
    repeat (6) tick();
    llu_valid = 1; llu_rd = 0; llu_data = 32'h55;
    chk("rd0_ready_before", llu_ready, 1);
    tick();
    llu_valid = 0;
    chk("rd0_llu_ready", llu_ready, 1);
    chk("rd0_llu_pending", llu_pending, 0);
    pipe_valid = 1; pipe_rd = 2; pipe_data = 32'hBBBB0002;
    llu_valid = 1; llu_rd = 10; llu_data = 32'hA0;
    tick();
    llu_rd = 11; llu_data = 32'hB0;
    tick();
    llu_valid = 0;
    chk("pre_arst_pending", llu_pending, 1);
    async_reset_mid_cycle();
    tick();
    chk("post_arst_pending", llu_pending, 0);
    for (int i = 0; i < 3000; i++) begin
      if (!seen_stall) begin
        pipe_valid = $urandom_range(0, 99) < 60;
        pipe_rd = 5'($urandom);
        pipe_data = $urandom;
      end
      llu_valid = $urandom_range(0, 99) < 35;
      llu_rd = 5'($urandom_range(0, 31));
      llu_data = $urandom;
      if (i == 1500) async_reset_mid_cycle();
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback result and a long-latency unit (LLU, e.g. mul/div) that completes out of band.
- Pipeline results normally win the port; LLU results queue in a small buffer and drain in free slots.
- An age counter and a full-buffer check force a drain by stalling the pipeline for one cycle.
- Sits between the writeback mux output and the register file; the issue scoreboard guarantees no WAW between a pending LLU op and a younger pipeline write.

Parameters:
DEPTH, 2, LLU result buffer entries (power of 2, >=2)
MAX_WAIT, 8, cycles a non-empty buffer head may wait before a forced drain
XLEN, 32, data width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
pipe_valid  in  1  pipeline writeback result valid this cycle
pipe_rd  in  5  pipeline destination register
pipe_data  in  XLEN  pipeline result (ResultW)
stall_pipe  out  1  combinational; pipeline must hold its writeback inputs this cycle
llu_valid  in  1  LLU result offered
llu_ready  out  1  buffer can accept (registered, = !full)
llu_rd  in  5  LLU destination register
llu_data  in  XLEN  LLU result
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  5  register-file write address (registered)
rf_wdata  out  XLEN  register-file write data (registered)
llu_pending  out  1  buffer non-empty (registered)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, llu_ready=1, llu_pending=0.
- Reset state: buffer empty, age=0, state=NORMAL.
- Reset mid-operation discards all buffered results.
- Enqueue: on llu_valid && llu_ready, push {rd,data}.
  - If llu_rd==0, the handshake still completes but nothing is pushed.
- Buffer: circular FIFO with wrap-around read/write pointers and a count.
  - Push and pop in the same cycle with count==DEPTH is legal: count unchanged.
  - llu_ready recomputes each cycle from the next count.
- State machine:
  - NORMAL:
    - If force is true, grant the buffer head, assert stall_pipe, go to DRAIN for that cycle.
    - Else if pipe_valid, grant the pipeline.
    - Else if the buffer is non-empty, grant the head.
    - Else idle.
  - force = buffer non-empty && (age==MAX_WAIT || (count==DEPTH && llu_valid)).
  - DRAIN: lasts exactly one cycle, then returns to NORMAL.
    - Minimum one unforced cycle between forced drains, so the pipeline is never stalled two cycles in a row.
- age:
  - Resets to 0 whenever the head is popped or the buffer is empty.
  - Otherwise increments, saturating at MAX_WAIT.
- Grant to write port: latency 1.
  - rf_we, rf_waddr and rf_wdata are registered from the granted source on the next rising edge.
  - A pipeline grant with pipe_rd==0 yields rf_we=0.
- stall_pipe depends only on registered state and llu_valid. It never depends on pipe_valid, so there is no combinational loop with hazard logic.
- With no grant, rf_we=0; rf_waddr and rf_wdata hold their previous values.

Decomposition:
- Shared package: XLEN, REG_ADDR_W=5, the state encoding (NORMAL, DRAIN) and a wb_req struct/typedef {rd, data}.
- Natural sub-module: wb_result_fifo (parameterised DEPTH circular buffer with count, full and empty). Arbitration FSM and age counter stay in the top.

Test Plan:
- Reset, then idle: rf_we=0, llu_ready=1, llu_pending=0, stall_pipe=0 for 5 cycles.
- Apply rst asynchronously mid-cycle with 2 entries buffered: outputs clear immediately and the buffer empties.
- pipe_valid=1, rd=5, data=0xDEADBEEF, no LLU: next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF.
- Same with rd=0: rf_we=0.
- LLU pushes rd=7, data=0x11 while the pipeline is busy every cycle (MAX_WAIT=8):
  - Entry waits.
  - On the 9th cycle stall_pipe=1 and the head is granted.
  - Next cycle rf_waddr=7, rf_wdata=0x11.
  - The following cycle stall_pipe=0.
- DEPTH=2 filled (rd=3, rd=4) with llu_valid held and the pipeline busy:
  - llu_ready=0.
  - A forced drain writes rd=3 first, then rd=4, in FIFO order.
- Simultaneous push and pop at count==DEPTH across pointer wrap: data order is preserved, count stays 2, llu_ready stays 0.
- LLU push with llu_rd=0: handshake completes and llu_pending stays 0.
